// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
`timescale 1ns/1ps
package mem_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    LS_WORD   = 3'b000,
    LS_HALF_S = 3'b001,
    LS_BYTE_S = 3'b010,
    LS_HALF_U = 3'b011,
    LS_BYTE_U = 3'b100
  } ls_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

  // Lanes touched by an access before it is shifted to its byte offset.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] op);
    logic [LANES-1:0] m;
    case (op)
      LS_HALF_S, LS_HALF_U: m = 4'b0011;
      LS_BYTE_S, LS_BYTE_U: m = 4'b0001;
      default:              m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] raw);
    logic [31:0] v;
    case (op)
      LS_HALF_S: v = {{16{raw[15]}}, raw[15:0]};
      LS_HALF_U: v = {16'h0000, raw[15:0]};
      LS_BYTE_S: v = {{24{raw[7]}}, raw[7:0]};
      LS_BYTE_U: v = {24'h000000, raw[7:0]};
      default:   v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered,
// write-first read port.
`timescale 1ns/1ps
module byte_lane_ram import mem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [LANES-1:0]   be_i,
  input  logic [8*LANES-1:0] wdata_i,
  output logic [8*LANES-1:0] rdata_o
);

  logic [8*LANES-1:0] mem_q [DEPTH];
  logic [8*LANES-1:0] merged_s;

  // Read data reflects the lanes being written in the same cycle.
  always_comb begin
    merged_s = mem_q[addr_i];
    for (int i = 0; i < LANES; i++) begin
      if (be_i[i]) begin
        merged_s[8*i +: 8] = wdata_i[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = mem_q[addr_i][8*i +: 8];
      end
    end
  end

  // Byte-lane write and registered read.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= merged_s;
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store responder: lane alignment, misaligned word splitting, range
// faults and stall generation in front of a synchronous byte-lane RAM.
`timescale 1ns/1ps
module data_mem_unit import mem_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       ls_src,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] write_data_mod,
  output logic [WIDTH-1:0] data_in,
  output logic             resp_valid,
  output logic             stall,
  output logic             addr_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(4 * DEPTH);
  localparam logic [WIDTH-2:0] WORD_LIMIT = (WIDTH-1)'(DEPTH);

  mem_state_t state_q, state_d;

  logic [1:0]         off_s;
  logic [LANES-1:0]   mask_s;
  logic [2*LANES-1:0] wide_be_s;
  logic [2*WIDTH-1:0] wide_wd_s;
  logic [WIDTH-2:0]   next_word_s;
  logic               split_s, fault_s, accept_s;

  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic             we_q, split_q, fault_q;
  logic [AW-1:0]    word_q;
  logic [WIDTH-1:0] hi_wd_q, low_q, hold_q;
  logic [LANES-1:0] hi_be_q;

  logic [AW-1:0]      ram_addr_s;
  logic [LANES-1:0]   ram_be_s;
  logic [WIDTH-1:0]   ram_wd_s, ram_rdata_s, load_val_s;
  logic [2*WIDTH-1:0] combined_s, shifted_s;

  // Lanes spilling into the upper half of the 64-bit window mark a split access.
  assign off_s       = alu_out[1:0];
  assign mask_s      = lane_mask(ls_src);
  assign wide_be_s   = {{LANES{1'b0}}, mask_s} << off_s;
  assign wide_wd_s   = {{WIDTH{1'b0}}, write_data_mod} << {off_s, 3'b000};
  assign split_s     = |wide_be_s[2*LANES-1:LANES];
  assign next_word_s = {1'b0, alu_out[WIDTH-1:2]} + {{(WIDTH-2){1'b0}}, 1'b1};
  assign fault_s     = (alu_out >= ADDR_LIMIT) || (split_s && (next_word_s >= WORD_LIMIT));
  assign accept_s    = !rst && req_valid && (state_q != SECOND);

  // RAM port: live request in IDLE/RESP, captured upper word in SECOND.
  always_comb begin
    if (state_q == SECOND) begin
      ram_addr_s = word_q + AW'(1);
      ram_wd_s   = hi_wd_q;
      ram_be_s   = (we_q && !fault_q) ? hi_be_q : {LANES{1'b0}};
    end else begin
      ram_addr_s = alu_out[AW+1:2];
      ram_wd_s   = wide_wd_s[WIDTH-1:0];
      ram_be_s   = (accept_s && req_we && !fault_s) ? wide_be_s[LANES-1:0] : {LANES{1'b0}};
    end
  end

  byte_lane_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr_s),
    .be_i    (ram_be_s),
    .wdata_i (ram_wd_s),
    .rdata_o (ram_rdata_s)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_s && split_s) begin
          state_d = SECOND;
        end else if (accept_s && !req_we) begin
          state_d = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      SECOND:  state_d = we_q ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Load assembly: {high, low} window shifted down to the byte offset.
  always_comb begin
    if (split_q) begin
      combined_s = {ram_rdata_s, low_q};
    end else begin
      combined_s = {{WIDTH{1'b0}}, ram_rdata_s};
    end
    shifted_s = combined_s >> {off_q, 3'b000};
    if (fault_q) begin
      load_val_s = {WIDTH{1'b0}};
    end else begin
      load_val_s = load_extend(op_q, shifted_s[WIDTH-1:0]);
    end
  end

  // State and request capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      fault_q <= 1'b0;
      word_q  <= {AW{1'b0}};
      hi_wd_q <= {WIDTH{1'b0}};
      hi_be_q <= {LANES{1'b0}};
      low_q   <= {WIDTH{1'b0}};
      hold_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        op_q    <= ls_src;
        off_q   <= off_s;
        we_q    <= req_we;
        split_q <= split_s;
        fault_q <= fault_s;
        word_q  <= alu_out[AW+1:2];
        hi_wd_q <= wide_wd_s[2*WIDTH-1:WIDTH];
        hi_be_q <= wide_be_s[2*LANES-1:LANES];
      end
      if (state_q == SECOND) begin
        low_q <= ram_rdata_s;
      end
      if (state_q == RESP) begin
        hold_q <= load_val_s;
      end
    end
  end

  assign data_in    = (state_q == RESP) ? load_val_s : hold_q;
  assign resp_valid = (state_q == RESP);
  assign stall      = !rst && req_valid &&
                      ((state_q == SECOND) ? !we_q : !(req_we && !split_s));
  assign addr_fault = !rst && ((accept_s && req_we && !split_s && fault_s) ||
                               ((state_q == SECOND) && we_q && fault_q) ||
                               ((state_q == RESP) && fault_q));

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: byte-array reference model plus an
// expected-load scoreboard queue.
`timescale 1ns/1ps
module tb_data_mem_unit;
  import mem_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  ls_src = 3'b000;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] write_data_mod = 32'h0;
  logic [31:0] data_in;
  logic        resp_valid, stall, addr_fault;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  data_mem_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .ls_src         (ls_src),
    .alu_out        (alu_out),
    .write_data_mod (write_data_mod),
    .data_in        (data_in),
    .resp_valid     (resp_valid),
    .stall          (stall),
    .addr_fault     (addr_fault)
  );

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'b001, 3'b011: return 2;
      3'b010, 3'b100: return 1;
      default:        return 4;
    endcase
  endfunction

  function automatic bit is_split(input logic [2:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) + op_size(op)) > 4;
  endfunction

  function automatic bit is_fault(input logic [2:0] op, input logic [31:0] addr);
    return (addr >= 32'(NBYTES)) ||
           (is_split(op, addr) && (((addr >> 2) + 32'd1) >= 32'(DEPTH)));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v;
    v = 32'h0;
    if (is_fault(op, addr)) return 32'h0;
    for (int i = 0; i < op_size(op); i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
    if (op == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
    if (op == 3'b010 && v[7])  v[31:8]  = 24'hFFFFFF;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < op_size(op); i++) ref_mem[int'(addr) + i] = data[8*i +: 8];
  endtask

  task automatic do_store(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
    bit sp, ft;
    sp = is_split(op, addr);
    ft = is_fault(op, addr);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; ls_src = op; alu_out = addr; write_data_mod = data;
    @(negedge clk);
    total_cnt++;
    if (stall !== sp) $display("FAIL %s stall_c0: got %b expected %b", tag, stall, sp);
    else pass_cnt++;
    total_cnt++;
    if (addr_fault !== (ft && !sp)) $display("FAIL %s fault_c0: got %b expected %b", tag, addr_fault, ft && !sp);
    else pass_cnt++;
    if (sp) begin
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL %s stall_c1: got %b expected 0", tag, stall);
      else pass_cnt++;
      total_cnt++;
      if (addr_fault !== ft) $display("FAIL %s fault_c1: got %b expected %b", tag, addr_fault, ft);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    if (!ft) model_store(op, addr, data);
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input string tag);
    bit sp, ft;
    logic [31:0] e;
    sp = is_split(op, addr);
    ft = is_fault(op, addr);
    exp_q.push_back(model_load(op, addr));
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; ls_src = op; alu_out = addr;
    @(negedge clk);
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL %s stall_c0: got %b expected 1", tag, stall);
    else pass_cnt++;
    if (sp) begin
      @(negedge clk);
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL %s stall_c1: got %b expected 1", tag, stall);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    total_cnt++;
    if (resp_valid !== 1'b1 || stall !== 1'b0)
      $display("FAIL %s resp: got valid=%b stall=%b expected valid=1 stall=0", tag, resp_valid, stall);
    else pass_cnt++;
    total_cnt++;
    if (addr_fault !== ft) $display("FAIL %s fault: got %b expected %b", tag, addr_fault, ft);
    else pass_cnt++;
    total_cnt++;
    if (data_in !== e) $display("FAIL %s data: got %h expected %h", tag, data_in, e);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; alu_out = 32'h10;
    #12;
    total_cnt++;
    if (data_in !== 32'h0 || resp_valid !== 1'b0 || stall !== 1'b0 || addr_fault !== 1'b0)
      $display("FAIL reset_outputs: got data=%h valid=%b stall=%b fault=%b expected all 0",
               data_in, resp_valid, stall, addr_fault);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_store(LS_WORD, 32'h0C, 32'h55667788, "st_0c");
    do_store(LS_WORD, 32'h10, 32'hDEADBEEF, "st_10");
    do_load(LS_WORD,   32'h10, "ld_w_10");
    do_load(LS_HALF_S, 32'h12, "ld_hs_12");
    do_load(LS_HALF_U, 32'h12, "ld_hu_12");
    do_load(LS_BYTE_S, 32'h11, "ld_bs_11");
    do_load(LS_BYTE_U, 32'h11, "ld_bu_11");
  endtask

  task automatic test_split_store();
    do_store(LS_HALF_U, 32'h13, 32'h00001234, "st_h_13");
    do_load(LS_WORD,   32'h10, "ld_w_10_after");
    do_load(LS_BYTE_U, 32'h14, "ld_bu_14");
  endtask

  task automatic test_misaligned_load();
    do_load(LS_WORD, 32'h0E, "ld_w_0e");
    total_cnt++;
    if (data_in[31:16] !== 16'hBEEF) $display("FAIL ld_w_0e_hi: got %h expected beef", data_in[31:16]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; ls_src = LS_WORD; alu_out = 32'h24; write_data_mod = 32'h9B135724;
    @(negedge clk);
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL b2b_store_stall: got %b expected 0", stall);
    else pass_cnt++;
    model_store(LS_WORD, 32'h24, 32'h9B135724);
    @(posedge clk); #1;
    req_we = 1'b0; ls_src = LS_WORD; alu_out = 32'h24;
    exp_q.push_back(model_load(LS_WORD, 32'h24));
    @(negedge clk);
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL b2b_ld1_stall: got %b expected 1", stall);
    else pass_cnt++;
    @(posedge clk); #1;
    ls_src = LS_BYTE_S; alu_out = 32'h27;
    exp_q.push_back(model_load(LS_BYTE_S, 32'h27));
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if (resp_valid !== 1'b1 || data_in !== e || stall !== 1'b1)
      $display("FAIL b2b_raw: got valid=%b data=%h stall=%b expected valid=1 data=%h stall=1",
               resp_valid, data_in, stall, e);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++;
    if (resp_valid !== 1'b1 || data_in !== e)
      $display("FAIL b2b_ld2: got valid=%b data=%h expected valid=1 data=%h", resp_valid, data_in, e);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (resp_valid !== 1'b0 || data_in !== e)
      $display("FAIL data_hold: got valid=%b data=%h expected valid=0 data=%h", resp_valid, data_in, e);
    else pass_cnt++;
  endtask

  task automatic test_fault();
    do_store(LS_WORD, 32'h000, 32'h0BADF00D, "st_000");
    do_store(LS_WORD, 32'hFFC, 32'h600DCAFE, "st_ffc");
    do_store(LS_WORD, 32'(NBYTES), 32'hFFFFFFFF, "st_oob");
    do_load(LS_WORD, 32'h000, "ld_000_after_oob");
    do_store(LS_WORD, 32'(NBYTES - 2), 32'h12345678, "st_split_oob");
    do_load(LS_WORD, 32'hFFC, "ld_ffc_after_oob");
    do_load(LS_BYTE_U, 32'(NBYTES + 1), "ld_oob");
  endtask

  task automatic test_reset_in_second();
    do_store(LS_WORD, 32'h1C, 32'h11223344, "st_1c");
    do_store(LS_WORD, 32'h20, 32'hA5A5A5A5, "st_20");
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; ls_src = LS_WORD; alu_out = 32'h1E; write_data_mod = 32'hCAFEF00D;
    @(negedge clk);
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL rst2_stall_c0: got %b expected 1", stall);
    else pass_cnt++;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (data_in !== 32'h0 || resp_valid !== 1'b0 || stall !== 1'b0 || addr_fault !== 1'b0)
      $display("FAIL rst2_outputs: got data=%h valid=%b stall=%b fault=%b expected all 0",
               data_in, resp_valid, stall, addr_fault);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    ref_mem[32'h1E] = 8'h0D;
    ref_mem[32'h1F] = 8'hF0;
    do_load(LS_WORD, 32'h1C, "ld_1c_after_rst");
    do_load(LS_WORD, 32'h20, "ld_20_after_rst");
    do_store(LS_WORD, 32'h28, 32'h01020304, "st_idle_after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split_store();
    test_misaligned_load();
    test_back_to_back();
    test_fault();
    test_reset_in_second();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Load/store responder on the datapath's data-memory port. Takes the byte address (`alu_out`), store data (`write_data_mod`) and access type (`ls_src`). Returns the fully sign- or zero-extended load value on `data_in`. Internally it handles byte-lane enables, word splitting for misaligned accesses and a synchronous-read RAM, and raises `stall` so the control unit freezes the PC while a multi-cycle access completes.

## Interface
- `WIDTH`, 32, data and address width.
- `DEPTH`, 1024, RAM size in 32-bit words; the byte address space is 0 to 4·DEPTH−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  a memory access is requested this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `ls_src`  in  3  access type, from `ls_op_t`.
- `alu_out`  in  WIDTH  byte address.
- `write_data_mod`  in  WIDTH  store data, right-justified.
- `data_in`  out  WIDTH  load result, extended; valid while `resp_valid`=1.
- `resp_valid`  out  1  one-cycle pulse when a load result is present.
- `stall`  out  1  combinational; 1 = hold PC, request and operands stable.
- `addr_fault`  out  1  one-cycle pulse when an access falls outside the RAM.

## Operation
- `ls_op_t` encoding:
  - 000 word.
  - 001 half signed.
  - 010 byte signed.
  - 011 half unsigned.
  - 100 byte unsigned.
  - Stores ignore signedness; 101–111 are treated as word.
- Misaligned access: a word with `alu_out[1:0]`≠0, or a half with `alu_out[1:0]`=3. Byte accesses are never misaligned.
- FSM states:
  - IDLE: accepts requests.
    - Aligned load goes to RESP.
    - Misaligned load or store goes to SECOND.
    - Aligned store completes in IDLE; RAM is written at the end of the accept cycle.
  - SECOND: accesses word `addr/4+1`.
    - A load goes to RESP.
    - A store returns to IDLE.
  - RESP: drives `data_in` and `resp_valid`=1, then returns to IDLE. A new request may be accepted in the same cycle (back-to-back).
- `stall` = `req_valid` & not (the access completes this cycle). The requester holds all inputs while `stall`=1.
- Loads: the low word's bytes and (if split) the high word's bytes are concatenated, shifted by `alu_out[1:0]·8` and extended per `ls_src`.
- Stores: data is shifted left by `alu_out[1:0]·8` and byte enables are generated.
  - A split store writes the low lanes in the accept cycle and the remaining lanes in SECOND.
- Fault: `alu_out` ≥ 4·DEPTH, or a split whose second word is ≥ DEPTH.
  - No RAM write occurs.
  - `addr_fault` pulses in the cycle the access would complete.
  - A faulting load returns 0 with normal latency.
- Reset:
  - FSM goes to IDLE; `data_in`, `resp_valid`, `stall` and `addr_fault` are all 0.
  - RAM contents are not reset.
  - Reset in SECOND abandons the store; the low word is already written and stays written.

## Timing
- Cycle 0 is the accept cycle (`req_valid`=1 sampled in IDLE or RESP).
- Aligned load:
  - `stall`=1 in cycle 0.
  - `data_in`/`resp_valid` valid in cycle 1, with `stall`=0.
- Misaligned load:
  - `stall`=1 in cycles 0–1.
  - Result in cycle 2.
- Aligned store: `stall`=0; RAM is updated at the end of cycle 0.
- Misaligned store: `stall`=1 in cycle 0 and 0 in cycle 1; the second write lands at the end of cycle 1.
- Read-after-write to the same word in consecutive cycles returns the new data (RAM is write-first).
- `data_in` holds its last value after `resp_valid` drops.

## Structure
- Package `mem_pkg`: `ls_op_t` enum, `mem_state_t` {IDLE, SECOND, RESP}, and a localparam for the byte-lane count (4).
- Sub-module `byte_lane_ram`:
  - DEPTH×32 array with 4-bit byte enable and synchronous write-first read.
  - Instantiated once; the top holds the FSM, lane shifting and extension.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x10; load word at 0x10 → `stall` 1 cycle, then `data_in`=0xDEADBEEF with `resp_valid`=1.
- Load half signed at 0x12 → 0xFFFFDEAD. Load half unsigned at 0x12 → 0x0000DEAD. Load byte signed at 0x11 → 0xFFFFFFBE. Load byte unsigned at 0x11 → 0x000000BE.
- Store half 0x1234 at 0x13 (split):
  - `stall` high for 1 cycle.
  - Load word at 0x10 → 0x34ADBEEF.
  - Load byte unsigned at 0x14 → 0x00000012.
- Load word at 0x0E (misaligned) after the above → `stall` 2 cycles, result 0xBEEFxxxx with the low half from word 0x0C, checked against a reference model.
- Store word at 4·DEPTH → `addr_fault` pulse and no RAM change. Load byte at 4·DEPTH+1 → `addr_fault` and `data_in`=0.
- Assert `rst` during SECOND of a split store at 0x1E → outputs go to 0 immediately, FSM is IDLE, word 0x1C is modified and word 0x20 is unchanged.
